// File: rtl/chaotic_x_update_fx.sv
// chaotic_x_update_fx: fixed-point x(n+1) = a*y + c*NL(e*p(z)*y)
// with an external variable-latency NL unit and FIFO-aligned bypass.
module chaotic_x_update_fx #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [DATA_WIDTH-1:0] e,
  input  logic [DATA_WIDTH-1:0] k0,
  input  logic [DATA_WIDTH-1:0] k1,
  input  logic [DATA_WIDTH-1:0] k2,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] yn,
  input  logic [DATA_WIDTH-1:0] zn,
  output logic                  nl_req_valid,
  input  logic                  nl_req_ready,
  output logic [DATA_WIDTH-1:0] nl_req_data,
  input  logic                  nl_rsp_valid,
  output logic                  nl_rsp_ready,
  input  logic [DATA_WIDTH-1:0] nl_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] xn1,
  output logic                  busy,
  output logic                  sat_flag,
  output logic                  proto_err,
  input  logic                  clr_flags
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  // All helpers return {saturated, word}.
  function automatic logic [W:0] f_sat2(
    input logic [2*W-1:0] v
  );
    logic [W:0] r;
    if (v[2*W-1:W-1] == {(W+1){1'b0}} ||
        v[2*W-1:W-1] == {(W+1){1'b1}})
      r = {1'b0, v[W-1:0]};
    else
      r = {1'b1, v[2*W-1], {(W-1){~v[2*W-1]}}};
    return r;
  endfunction

  function automatic logic [W:0] f_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic signed [2*W-1:0] p;
    p = $signed({{W{x[W-1]}}, x}) *
        $signed({{W{y[W-1]}}, y});
    return f_sat2(p >>> FRAC_BITS);
  endfunction

  function automatic logic [W:0] f_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W:0] s;
    logic [W:0] r;
    s = {x[W-1], x} + {y[W-1], y};
    if (s[W] != s[W-1])
      r = {1'b1, s[W], {(W-1){~s[W]}}};
    else
      r = {1'b0, s[W-1:0]};
    return r;
  endfunction

  logic          r_v1, r_v2, r_v3;
  logic [W-1:0]  r_zz, r_k1z, r_ey1, r_ay1;
  logic [W-1:0]  r_p, r_ey2, r_ay2;
  logic [W-1:0]  r_arg, r_ay3;
  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ov;
  logic [W-1:0]  r_xn1;
  logic          r_sat, r_perr;

  logic          w_stall, w_adv;
  logic          w_in_fire, w_req_fire;
  logic          w_rsp_fire, w_pop;
  logic [CW-1:0] w_inflight;
  logic [W:0]    w_zz, w_k1z, w_ey, w_ay;
  logic [W:0]    w_k2zz, w_s01, w_p, w_arg;
  logic [W:0]    w_cnl, w_x;
  logic          w_sat_any;

  assign w_stall = r_v3 & ~nl_req_ready;
  assign w_adv   = ~w_stall;

  // Credit covers everything between input and NL response.
  assign w_inflight = r_cnt + CW'(r_v1)
                    + CW'(r_v2) + CW'(r_v3);
  assign in_ready   = w_adv &&
                      (w_inflight < CW'(FIFO_DEPTH));
  assign w_in_fire  = in_valid & in_ready;
  assign w_req_fire = r_v3 & nl_req_ready;

  assign nl_rsp_ready = ~r_ov | out_ready;
  assign w_rsp_fire   = nl_rsp_valid & nl_rsp_ready;
  assign w_pop        = w_rsp_fire & (r_cnt != '0);

  assign w_zz   = f_mul(zn, zn);
  assign w_k1z  = f_mul(k1, zn);
  assign w_ey   = f_mul(e, yn);
  assign w_ay   = f_mul(a, yn);
  assign w_k2zz = f_mul(k2, r_zz);
  assign w_s01  = f_add(k0, r_k1z);
  assign w_p    = f_add(w_s01[W-1:0], w_k2zz[W-1:0]);
  assign w_arg  = f_mul(r_p, r_ey2);
  assign w_cnl  = f_mul(c, nl_rsp_data);
  assign w_x    = f_add(r_mem[r_rp], w_cnl[W-1:0]);

  assign w_sat_any =
      (w_in_fire & (w_zz[W] | w_k1z[W] |
                    w_ey[W] | w_ay[W])) |
      (w_adv & r_v1 & (w_k2zz[W] | w_s01[W] |
                       w_p[W])) |
      (w_adv & r_v2 & w_arg[W]) |
      (w_pop & (w_cnl[W] | w_x[W]));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= w_in_fire;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_zz  <= w_zz[W-1:0];
      r_k1z <= w_k1z[W-1:0];
      r_ey1 <= w_ey[W-1:0];
      r_ay1 <= w_ay[W-1:0];
      r_p   <= w_p[W-1:0];
      r_ey2 <= r_ey1;
      r_ay2 <= r_ay1;
      r_arg <= w_arg[W-1:0];
      r_ay3 <= r_ay2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire)
      r_mem[r_wp] <= r_ay3;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_req_fire)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_req_fire)
             - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ov  <= 1'b0;
      r_xn1 <= '0;
    end else if (w_pop) begin
      r_ov  <= 1'b1;
      r_xn1 <= w_x[W-1:0];
    end else if (out_ready) begin
      r_ov  <= 1'b0;
    end
  end

  // A new event in the clearing cycle keeps its flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_sat  <= (r_sat & ~clr_flags) | w_sat_any;
      r_perr <= (r_perr & ~clr_flags) |
                (w_rsp_fire & (r_cnt == '0));
    end
  end

  assign nl_req_valid = r_v3;
  assign nl_req_data  = r_arg;
  assign out_valid    = r_ov;
  assign xn1          = r_xn1;
  assign sat_flag     = r_sat;
  assign proto_err    = r_perr;
  assign busy = r_v1 | r_v2 | r_v3 |
                (r_cnt != '0) | r_ov;

endmodule
